// File: rtl/ami_sector_responder.sv
// ---------------------------------------------------------------------------
// ami_sector_responder
//   Memory-side responder for the AMI request bus. Accepts packed requests,
//   stores write data in a single block of NUM_SECTORS x SECTOR_WIDTH sectors
//   and returns packed responses for reads after RESP_LATENCY cycles.
//   Sector index = addr[5:3]; lower and higher address bits are ignored, so
//   every block address aliases onto the same store.
//
// Ports
//   clk             clock, all state on rising edge
//   rst             asynchronous, active-high reset
//   req_in          {size, data, addr, is_write, valid}
//   req_in_grant    request accepted this cycle (combinational)
//   resp_out        {size, data, valid}, registered
//   resp_out_grant  consumer accepts resp_out this cycle
//   err_bad_size    sticky: a request with a size other than 8 or 64 bytes
//                   was accepted
// ---------------------------------------------------------------------------
module ami_sector_responder #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 576,
    parameter int SIZE_WIDTH   = 6,
    parameter int NUM_SECTORS  = 8,
    parameter int SECTOR_WIDTH = 64,
    parameter int RESP_LATENCY = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [SIZE_WIDTH+DATA_WIDTH+ADDR_WIDTH+1:0] req_in,
    output logic                                   req_in_grant,
    output logic [SIZE_WIDTH+DATA_WIDTH:0]         resp_out,
    input  logic                                   resp_out_grant,
    output logic                                   err_bad_size
);

    localparam int REQ_W   = SIZE_WIDTH + DATA_WIDTH + ADDR_WIDTH + 2;
    localparam int IDX_W   = $clog2(NUM_SECTORS);
    localparam int OFF_W   = $clog2(SECTOR_WIDTH / 8);
    localparam int BLOCK_W = NUM_SECTORS * SECTOR_WIDTH;
    localparam int CNT_W   = 4;

    // A full-block size of 64 bytes does not fit in the 6-bit size field and
    // therefore travels as its truncated encoding (0).
    localparam logic [SIZE_WIDTH-1:0] SIZE_SECTOR = SIZE_WIDTH'(SECTOR_WIDTH / 8);
    localparam logic [SIZE_WIDTH-1:0] SIZE_BLOCK  = SIZE_WIDTH'(BLOCK_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [SIZE_WIDTH-1:0]   lat_size;
    logic [IDX_W-1:0]        lat_idx;
    logic [SECTOR_WIDTH-1:0] sectors [NUM_SECTORS];

    logic                    resp_valid;
    logic [SIZE_WIDTH-1:0]   resp_size;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    err;

    // Request field decode
    logic                    req_valid;
    logic                    req_write;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [SIZE_WIDTH-1:0]   req_size;
    logic [IDX_W-1:0]        req_idx;
    logic                    size_ok;

    assign req_valid = req_in[0];
    assign req_write = req_in[1];
    assign req_addr  = req_in[ADDR_WIDTH+1:2];
    assign req_data  = req_in[DATA_WIDTH+ADDR_WIDTH+1:ADDR_WIDTH+2];
    assign req_size  = req_in[REQ_W-1 -: SIZE_WIDTH];
    assign req_idx   = req_addr[OFF_W +: IDX_W];
    assign size_ok   = (req_size == SIZE_SECTOR) || (req_size == SIZE_BLOCK);

    logic unused_req_bits;
    assign unused_req_bits = ^{req_addr[ADDR_WIDTH-1:OFF_W+IDX_W],
                               req_addr[OFF_W-1:0],
                               req_data[DATA_WIDTH-1:BLOCK_W]};

    // Reset also masks the grant so nothing is accepted while rst is high.
    assign req_in_grant = (state == IDLE) && req_valid && !rst;

    assign resp_out     = {resp_size, resp_data, resp_valid};
    assign err_bad_size = err;

    // Read data assembled from the latched size/index; bad sizes return 0.
    logic [DATA_WIDTH-1:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (lat_size == SIZE_SECTOR) begin
            rd_data[SECTOR_WIDTH-1:0] = sectors[lat_idx];
        end else if (lat_size == SIZE_BLOCK) begin
            for (int unsigned i = 0; i < NUM_SECTORS; i++) begin
                rd_data[i*SECTOR_WIDTH +: SECTOR_WIDTH] = sectors[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_size   <= '0;
            lat_idx    <= '0;
            resp_valid <= 1'b0;
            resp_size  <= '0;
            resp_data  <= '0;
            err        <= 1'b0;
            for (int unsigned i = 0; i < NUM_SECTORS; i++) begin
                sectors[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_in_grant) begin
                        if (!size_ok) begin
                            err <= 1'b1;
                        end
                        if (req_write) begin
                            if (req_size == SIZE_SECTOR) begin
                                sectors[req_idx] <= req_data[SECTOR_WIDTH-1:0];
                            end else if (req_size == SIZE_BLOCK) begin
                                for (int unsigned i = 0; i < NUM_SECTORS; i++) begin
                                    sectors[i] <= req_data[i*SECTOR_WIDTH +: SECTOR_WIDTH];
                                end
                            end
                        end else begin
                            lat_size <= req_size;
                            lat_idx  <= req_idx;
                            cnt      <= CNT_W'(RESP_LATENCY);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Data is sampled on the edge that enters RESP; no write
                    // can be accepted in WAIT, so the snapshot is coherent.
                    if (cnt == CNT_W'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_size  <= lat_size;
                        resp_data  <= rd_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_out_grant) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ami_sector_responder.sv
module tb_ami_sector_responder;

    logic         clk;
    logic         rst;
    logic [647:0] req_in;
    logic         req_in_grant;
    logic [582:0] resp_out;
    logic         resp_out_grant;
    logic         err_bad_size;

    int tests = 0;
    int fails = 0;

    ami_sector_responder #(
        .ADDR_WIDTH  (64),
        .DATA_WIDTH  (576),
        .SIZE_WIDTH  (6),
        .NUM_SECTORS (8),
        .SECTOR_WIDTH(64),
        .RESP_LATENCY(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_in        (req_in),
        .req_in_grant  (req_in_grant),
        .resp_out      (resp_out),
        .resp_out_grant(resp_out_grant),
        .err_bad_size  (err_bad_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] SZ8  = 6'd8;
    localparam logic [5:0] SZ64 = 6'd0;   // 64 truncated to the 6-bit field
    localparam logic [5:0] SZ16 = 6'd16;

    function automatic logic [647:0] mk_req(input logic wr, input logic [5:0] sz,
                                            input logic [63:0] ad, input logic [575:0] dt);
        return {sz, dt, ad, wr, 1'b1};
    endfunction

    // Present a request from a falling edge, hold until granted, drop it
    // just after the accepting edge. ok=0 if never granted.
    task automatic issue(input logic wr, input logic [5:0] sz, input logic [63:0] ad,
                         input logic [575:0] dt, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_in = mk_req(wr, sz, ad, dt);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_in_grant) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 req_in = '0;
    endtask

    // Called just after the accept edge; lat = edges until resp valid (0 = timeout).
    task automatic wait_resp(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_out[0]) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic ack_resp();
        resp_out_grant = 1'b1;
        @(posedge clk);
        #1 resp_out_grant = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_in = mk_req(1'b0, SZ8, 64'h0, '0);
        resp_out_grant = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (resp_out !== '0) begin
            fails++;
            $display("FAIL reset_resp: got %h want 0", resp_out);
        end
        tests++;
        if (req_in_grant !== 1'b0 || err_bad_size !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: grant=%b err=%b want 0 0", req_in_grant, err_bad_size);
        end
        req_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write8_read8();
        bit ok;
        int lat;
        logic [575:0] exp;
        issue(1'b1, SZ8, 64'h28, {512'h0, 64'hDEAD_BEEF_0000_0005}, ok);
        issue(1'b0, SZ8, 64'h28, '0, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL w8r8_grant: got 0 want 1");
        end
        wait_resp(lat);
        exp = '0;
        exp[63:0] = 64'hDEAD_BEEF_0000_0005;
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL w8r8_latency: got %0d want 2", lat);
        end
        tests++;
        if (resp_out[576:1] !== exp || resp_out[582:577] !== SZ8) begin
            fails++;
            $display("FAIL w8r8_data: got size %0d data %h want size 8 data %h",
                     resp_out[582:577], resp_out[576:1], exp);
        end
        ack_resp();
        tests++;
        if (resp_out[0] !== 1'b0) begin
            fails++;
            $display("FAIL w8r8_release: valid got %b want 0", resp_out[0]);
        end
    endtask

    task automatic test_block_write_read();
        bit ok;
        int lat;
        logic [575:0] blk;
        logic [575:0] exp;
        blk = '1;
        for (int i = 0; i < 8; i++) blk[i*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        issue(1'b1, SZ64, 64'h0, blk, ok);
        issue(1'b0, SZ64, 64'h0, '0, ok);
        wait_resp(lat);
        exp = '0;
        exp[511:0] = blk[511:0];
        tests++;
        if (lat !== 2 || resp_out[576:1] !== exp || resp_out[582:577] !== SZ64) begin
            fails++;
            $display("FAIL blk_read: lat %0d size %0d data %h want lat 2 size 0 data %h",
                     lat, resp_out[582:577], resp_out[576:1], exp);
        end
        ack_resp();
        // High address bits alias onto the same block.
        issue(1'b0, SZ8, 64'hABCD_0000_0000_1038, '0, ok);
        wait_resp(lat);
        exp = '0;
        exp[63:0] = 64'h8888_8888_8888_8888;
        tests++;
        if (resp_out[576:1] !== exp) begin
            fails++;
            $display("FAIL blk_sector7: got %h want %h", resp_out[576:1], exp);
        end
        ack_resp();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [582:0] snap;
        logic [575:0] exp;
        issue(1'b0, SZ8, 64'h10, '0, ok);
        wait_resp(lat);
        snap = resp_out;
        exp = '0;
        exp[63:0] = 64'h3333_3333_3333_3333;
        tests++;
        if (snap[576:1] !== exp) begin
            fails++;
            $display("FAIL bp_first_data: got %h want %h", snap[576:1], exp);
        end
        req_in = mk_req(1'b0, SZ8, 64'h18, '0);
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (resp_out !== snap || req_in_grant !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: resp %h grant %b want resp %h grant 0",
                         i, resp_out, req_in_grant, snap);
            end
            @(posedge clk);
            #1;
        end
        resp_out_grant = 1'b1;
        @(posedge clk);
        #1 resp_out_grant = 1'b0;
        tests++;
        if (resp_out[0] !== 1'b0 || req_in_grant !== 1'b1) begin
            fails++;
            $display("FAIL bp_after_grant: valid %b grant %b want 0 1", resp_out[0], req_in_grant);
        end
        @(posedge clk);
        #1 req_in = '0;
        wait_resp(lat);
        exp[63:0] = 64'h4444_4444_4444_4444;
        tests++;
        if (lat !== 2 || resp_out[576:1] !== exp) begin
            fails++;
            $display("FAIL bp_second: lat %0d data %h want lat 2 data %h", lat, resp_out[576:1], exp);
        end
        ack_resp();
    endtask

    task automatic test_bad_size();
        bit ok;
        int lat;
        logic [575:0] exp;
        issue(1'b0, SZ16, 64'h0, '0, ok);
        tests++;
        if (err_bad_size !== 1'b1) begin
            fails++;
            $display("FAIL bad_err_set: got %b want 1", err_bad_size);
        end
        wait_resp(lat);
        tests++;
        if (lat !== 2 || resp_out[576:1] !== '0 || resp_out[582:577] !== SZ16) begin
            fails++;
            $display("FAIL bad_resp: lat %0d size %0d data %h want lat 2 size 16 data 0",
                     lat, resp_out[582:577], resp_out[576:1]);
        end
        ack_resp();
        issue(1'b1, SZ16, 64'h0, {9{64'hBAD0_BAD0_BAD0_BAD0}}, ok);
        issue(1'b0, SZ8, 64'h0, '0, ok);
        wait_resp(lat);
        exp = '0;
        exp[63:0] = 64'h1111_1111_1111_1111;
        tests++;
        if (resp_out[576:1] !== exp || err_bad_size !== 1'b1) begin
            fails++;
            $display("FAIL bad_store_kept: data %h err %b want %h err 1",
                     resp_out[576:1], err_bad_size, exp);
        end
        ack_resp();
    endtask

    task automatic test_reset_mid_resp();
        bit ok;
        int lat;
        issue(1'b0, SZ8, 64'h08, '0, ok);
        wait_resp(lat);
        rst = 1'b1;
        #1;
        tests++;
        if (resp_out[0] !== 1'b0 || err_bad_size !== 1'b0 || req_in_grant !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: valid %b err %b grant %b want 0 0 0",
                     resp_out[0], err_bad_size, req_in_grant);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, SZ64, 64'h0, '0, ok);
        wait_resp(lat);
        tests++;
        if (lat !== 2 || resp_out[576:1] !== '0) begin
            fails++;
            $display("FAIL rst_cleared_blk: lat %0d data %h want lat 2 data 0", lat, resp_out[576:1]);
        end
        ack_resp();
        issue(1'b0, SZ8, 64'h30, '0, ok);
        wait_resp(lat);
        tests++;
        if (resp_out[576:1] !== '0) begin
            fails++;
            $display("FAIL rst_cleared_sec: got %h want 0", resp_out[576:1]);
        end
        ack_resp();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        int grants;
        int stray;
        logic [575:0] exp;
        grants = 0;
        stray = 0;
        exp = '0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            req_in = mk_req(1'b1, SZ8, 64'hF000_0000_0000_0000 | 64'(i * 8),
                            {{8{64'hFFFF_0000_FFFF_0000}}, 64'h0123_4567_89AB_CD00 + 64'(i)});
            exp[i*64 +: 64] = 64'h0123_4567_89AB_CD00 + 64'(i);
            #1;
            if (req_in_grant === 1'b1) grants++;
            @(posedge clk);
            #1;
            if (resp_out[0] !== 1'b0) stray++;
            @(negedge clk);
        end
        req_in = '0;
        tests++;
        if (grants !== 8) begin
            fails++;
            $display("FAIL b2b_grants: got %0d want 8", grants);
        end
        tests++;
        if (stray !== 0) begin
            fails++;
            $display("FAIL b2b_no_resp: got %0d valid cycles want 0", stray);
        end
        issue(1'b0, SZ64, 64'h0, '0, ok);
        wait_resp(lat);
        tests++;
        if (resp_out[576:1] !== exp) begin
            fails++;
            $display("FAIL b2b_readback: got %h want %h", resp_out[576:1], exp);
        end
        ack_resp();
    endtask

    initial begin
        rst = 1'b1;
        req_in = '0;
        resp_out_grant = 1'b0;
        test_reset();
        test_write8_read8();
        test_block_write_read();
        test_backpressure();
        test_bad_size();
        test_reset_mid_resp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
